icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_if.sv | 37 +++
 rtl/icache_line_store.sv | 49 ++++
 rtl/icache.sv | 138 +++++++++++++
 tb/tb_icache.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared constants and types for the direct-mapped instruction cache.
//   - FSM state encoding (IDLE, MEM_READ, UPDATE)
//   - address field widths (tag / index / word offset) and line geometry
package icache_pkg;

    localparam int ADDR_W     = 10;   // CPU byte address width
    localparam int WORD_W     = 32;   // instruction word width
    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int LINE_W     = 128;
    localparam int NUM_BLOCKS = 8;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;   // block address to memory

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

endpackage

// File: rtl/icache_if.sv
// icache_if: CPU fetch port and instruction-memory port of the icache.
//   CPU side   : address (in), instruction (out), busywait (out)
//   memory side: mem_read (out), mem_address (out), mem_readdata (in),
//                mem_busywait (in)
// Modport slave is the cache's view; modport master is the environment's
// (CPU + instruction memory) view.
interface icache_if;

    logic [icache_pkg::ADDR_W-1:0]     address;
    logic [icache_pkg::WORD_W-1:0]     instruction;
    logic                              busywait;
    logic                              mem_read;
    logic [icache_pkg::MEM_ADDR_W-1:0] mem_address;
    logic [icache_pkg::LINE_W-1:0]     mem_readdata;
    logic                              mem_busywait;

    modport slave (
        input  address,
        input  mem_readdata,
        input  mem_busywait,
        output instruction,
        output busywait,
        output mem_read,
        output mem_address
    );

    modport master (
        output address,
        output mem_readdata,
        output mem_busywait,
        input  instruction,
        input  busywait,
        input  mem_read,
        input  mem_address
    );

endinterface

// File: rtl/icache_line_store.sv
// icache_line_store: valid / tag / data arrays of the direct-mapped cache.
//   clk, reset          : clock, asynchronous active-high reset (clears valid only)
//   rd_index            : combinational read port index
//   rd_valid/tag/data   : contents of the addressed line
//   wr_en, wr_index,
//   wr_tag, wr_data     : synchronous line write; also sets the line valid
module icache_line_store
    import icache_pkg::*;
#(
    parameter int DEPTH = NUM_BLOCKS
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_data
);

    logic [DEPTH-1:0]  valid;
    logic [TAG_W-1:0]  tags [DEPTH];
    logic [LINE_W-1:0] data [DEPTH];

    // Only the valid bits are reset; stale tag/data are masked by valid = 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

endmodule

// File: rtl/icache.sv
// icache: read-only, direct-mapped instruction cache (8 lines x 4 words).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : icache_if.slave
//                address -> tag [9:7], index [6:4], word [3:2], [1:0] ignored
//                instruction/busywait back to the CPU; a hit answers in the
//                same cycle, a miss stalls for memory latency + 2 cycles
//                mem_read/mem_address/mem_readdata/mem_busywait to the
//                instruction memory, one 128-bit block per fill
module icache #(
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4
)
(
    input  logic    clk,
    input  logic    reset,
    icache_if.slave bus
);

    import icache_pkg::*;

    localparam int LINE_BITS = WORDS_PER_BLOCK * WORD_W;

    state_t              state;
    state_t              state_next;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;
    logic [1:0]          unused_byte_offset;

    logic                line_valid;
    logic [TAG_W-1:0]    line_tag;
    logic [LINE_BITS-1:0] line_data;
    logic [WORD_W-1:0]   line_word;
    logic                hit;
    logic                hit_idle;

    logic [TAG_W-1:0]    miss_tag;
    logic [INDEX_W-1:0]  miss_index;
    logic [LINE_W-1:0]   fill_data;
    logic [WORD_W-1:0]   instr_q;

    logic                busy;
    logic                rd_req;
    logic                fill_we;

    assign req_offset         = bus.address[2 +: OFFSET_W];
    assign req_index          = bus.address[2 + OFFSET_W +: INDEX_W];
    assign req_tag            = bus.address[2 + OFFSET_W + INDEX_W +: TAG_W];
    assign unused_byte_offset = bus.address[1:0];

    icache_line_store #(
        .DEPTH (NUM_BLOCKS)
    ) u_store (
        .clk      (clk),
        .reset    (reset),
        .rd_index (req_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (fill_we),
        .wr_index (miss_index),
        .wr_tag   (miss_tag),
        .wr_data  (fill_data)
    );

    assign hit       = line_valid && (line_tag == req_tag);
    assign hit_idle  = (state == IDLE) && hit;
    assign line_word = line_data[WORD_W * req_offset +: WORD_W];

    // State and last-delivered instruction; reset here is asynchronous so an
    // in-flight fill is abandoned immediately and mem_read drops at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            instr_q <= '0;
        end else begin
            state <= state_next;
            if (hit_idle) begin
                instr_q <= line_word;
            end
        end
    end

    // Miss bookkeeping: the request is latched on the miss cycle so later
    // address changes cannot redirect the fill.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && !hit) begin
            miss_tag   <= req_tag;
            miss_index <= req_index;
        end
        if ((state == MEM_READ) && !bus.mem_busywait) begin
            fill_data <= bus.mem_readdata;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        rd_req     = 1'b0;
        fill_we    = 1'b0;
        case (state)
            IDLE: begin
                if (!hit) begin
                    busy       = 1'b1;
                    state_next = MEM_READ;
                end
            end
            MEM_READ: begin
                busy   = 1'b1;
                rd_req = 1'b1;
                if (!bus.mem_busywait) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                busy       = 1'b1;
                fill_we    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // With all lines invalid during reset every lookup misses; the CPU
        // must still see busywait low while reset is held.
        if (reset) begin
            busy = 1'b0;
        end
    end

    assign bus.busywait    = busy;
    assign bus.mem_read    = rd_req;
    assign bus.mem_address = {miss_tag, miss_index};
    // Hits are forwarded in the same cycle; otherwise the last word is held.
    assign bus.instruction = hit_idle ? line_word : instr_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache. The driver issues fetches and, from a
// block-level reference model (which memory block each index currently holds),
// pushes the expected instruction, stall length and memory block addresses.
// A monitor process checks the DUT outputs against those queues.
module tb_icache;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    icache_if bus();

    icache dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory: latency = number of mem_read cycles until capture.
    logic [127:0] mem [64];
    int latency   = 1;
    int rd_cycles = 0;

    assign bus.mem_readdata = mem[bus.mem_address];
    assign bus.mem_busywait = bus.mem_read && (rd_cycles < latency - 1);

    always @(posedge clk) rd_cycles <= bus.mem_read ? rd_cycles + 1 : 0;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] instr;
        int          stall;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] exp_maddr_q[$];
    int         resident[8];
    int         checks = 0;
    int         passes = 0;
    logic       active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        logic [127:0] blk;
        blk = mem[a[9:4]];
        return blk[32 * a[3:2] +: 32];
    endfunction

    // Returns 1 on a miss and records the block now resident at that index.
    function automatic bit model_access(input logic [9:0] a);
        int blk = int'(a[9:4]);
        int idx = blk % 8;
        if (resident[idx] == blk) return 1'b0;
        resident[idx] = blk;
        exp_maddr_q.push_back(a[9:4]);
        return 1'b1;
    endfunction

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (bus.busywait && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("fetch_done", 32'(bus.busywait), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [9:0] a, input int lat);
        exp_t e;
        latency = lat;
        e.addr  = a;
        e.instr = mem_word(a);
        e.stall = model_access(a) ? lat + 2 : 0;
        exp_q.push_back(e);
        bus.address = a;
        active      = 1'b1;
        wait_done();
    endtask

    // Fetch a1, then move the address to a2 during the first MEM_READ cycle.
    task automatic fetch_switch(input logic [9:0] a1, input logic [9:0] a2, input int lat);
        exp_t e;
        int   n = 0;
        latency = lat;
        e.addr  = a2;
        e.stall = model_access(a1) ? lat + 2 : 0;
        e.stall = e.stall + (model_access(a2) ? lat + 2 : 0);
        e.instr = mem_word(a2);
        exp_q.push_back(e);
        bus.address = a1;
        active      = 1'b1;
        while (!bus.mem_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        bus.address = a2;
        wait_done();
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    initial begin
        exp_t       e;
        int         stall = 0;
        logic       mr_prev = 1'b0;
        logic [31:0] last_instr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall      = 0;
                mr_prev    = 1'b0;
                last_instr = '0;
            end else begin
                if (bus.mem_read && !mr_prev) begin
                    check("mem_read_expected", 32'(exp_maddr_q.size() != 0), 32'd1);
                    if (exp_maddr_q.size() != 0)
                        check("mem_address", 32'(bus.mem_address), 32'(exp_maddr_q.pop_front()));
                end
                mr_prev = bus.mem_read;
                if (active) begin
                    if (bus.busywait) begin
                        stall++;
                        check("instr_hold", bus.instruction, last_instr);
                    end else begin
                        check("exp_available", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check($sformatf("instr@%03h", e.addr), bus.instruction, e.instr);
                            check($sformatf("stall@%03h", e.addr), 32'(stall), 32'(e.stall));
                        end
                        last_instr = bus.instruction;
                        stall      = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [9:0] a;
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) resident[i] = -1;
        reset       = 1'b1;
        bus.address = 10'h000;
        repeat (2) @(negedge clk);
        check("reset_busywait", 32'(bus.busywait), 32'd0);
        check("reset_mem_read", 32'(bus.mem_read), 32'd0);
        check("reset_instruction", bus.instruction, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Cold miss, then spatial hits on the same line.
        fetch(10'h000, 5);
        fetch(10'h004, 5);
        fetch(10'h008, 5);
        fetch(10'h00C, 5);

        // Conflict on index 0.
        fetch(10'h080, 4);
        fetch(10'h000, 3);

        // Address change during a miss; both lines must end up resident.
        fetch_switch(10'h010, 10'h3FC, 4);
        fetch(10'h014, 2);
        fetch(10'h3F8, 2);

        // Reset on the 2nd MEM_READ cycle abandons the fill.
        active      = 1'b0;
        latency     = 6;
        void'(model_access(10'h040));
        bus.address = 10'h040;
        n = 0;
        while (!bus.mem_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_fill_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_fill_busywait", 32'(bus.busywait), 32'd0);
        check("rst_fill_instruction", bus.instruction, 32'h0);
        for (int i = 0; i < 8; i++) resident[i] = -1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        fetch(10'h040, 2);

        // Random fetches, biased toward a small set of tags so hits occur.
        for (int i = 0; i < 150; i++) begin
            a = 10'($urandom);
            if ($urandom_range(0, 1) == 1) a[9:7] = 3'($urandom_range(0, 1));
            fetch(a, $urandom_range(1, 6));
        end

        // Looping 16-instruction program that wraps from 10'h3FC to 10'h000.
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 16; k++) fetch(10'(10'h3E0 + 4 * k), 3);
        end
        active = 1'b0;

        repeat (3) @(negedge clk);
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        check("maddr_drained", 32'(exp_maddr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
